// File: rtl/led_pattern_sequencer_if.sv
// led_pattern_sequencer_if: command handshake bundle carrying pattern, hold time and duty
interface led_pattern_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_pattern;
  logic [7:0] cmd_hold;
  logic [3:0] cmd_duty;
  modport master (output cmd_valid, cmd_pattern, cmd_hold, cmd_duty, input cmd_ready);
  modport slave (input cmd_valid, cmd_pattern, cmd_hold, cmd_duty, output cmd_ready);
endinterface

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: queued LED patterns shown for a tick-counted hold with PWM brightness
module led_pattern_sequencer #(
  parameter int DEPTH    = 4,
  parameter int PRESCALE = 100000
) (
  input  logic                     sys_clock,
  input  logic                     reset,
  led_pattern_sequencer_if.slave   cmd,
  output logic [3:0]               led_o,
  output logic [3:0]               led_t,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SHOW = 2'd2;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  logic [15:0]   mem [DEPTH];
  logic [15:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [7:0]    hold_cnt;
  logic [3:0]    pat, duty, pwm_cnt, lit;
  logic          push, pop, tick;
  assign cmd.cmd_ready = (fifo_level != FULL) && !reset;
  assign push = cmd.cmd_valid && cmd.cmd_ready;
  assign pop  = state == LOAD;
  assign tick = presc == P_LAST;
  assign head = mem[rd_ptr];
  assign busy = (state != IDLE) || (fifo_level != '0);
  assign lit  = pat & {4{(pwm_cnt < duty) || (duty == 4'hF)}};
  // FIFO storage, entry packed as {pattern, hold, duty}
  always_ff @(posedge sys_clock)
    if (push) mem[wr_ptr] <= {cmd.cmd_pattern, cmd.cmd_hold, cmd.cmd_duty};
  // FIFO pointers and occupancy; pops only come from LOAD, which is entered only with data present
  always_ff @(posedge sys_clock)
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= (push && !pop) ? fifo_level + 1'b1 :
                    (pop && !push) ? fifo_level - 1'b1 : fifo_level;
    end
  // sequencer: fetch head, then hold it for max(hold,1) prescaler ticks
  always_ff @(posedge sys_clock)
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      hold_cnt <= '0;
      pat      <= '0;
      duty     <= '0;
    end else if (state == IDLE) begin
      if (fifo_level != '0) state <= LOAD;
    end else if (state == LOAD) begin
      pat      <= head[15:12];
      hold_cnt <= (head[11:4] == 8'd0) ? 8'd1 : head[11:4];
      duty     <= head[3:0];
      presc    <= '0;
      state    <= SHOW;
    end else if (state == SHOW) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == 8'd1) state <= (fifo_level != '0) ? LOAD : IDLE;
      end
    end else begin
      state <= IDLE;
    end
  // free-running PWM phase and registered pad drive, released to pull-up outside SHOW
  always_ff @(posedge sys_clock)
    if (reset) begin
      pwm_cnt <= '0;
      led_t   <= 4'hF;
      led_o   <= 4'h0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led_t   <= (state == SHOW) ? 4'h0 : 4'hF;
      led_o   <= (state == SHOW) ? lit : 4'h0;
    end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed checks of queueing, timing, PWM and reset behaviour
module tb_led_pattern_sequencer;
  logic       sys_clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] led_o, led_t;
  logic       busy;
  logic [2:0] fifo_level;
  int checks = 0;
  int failures = 0;
  led_pattern_sequencer_if cmd ();
  led_pattern_sequencer #(.DEPTH(4), .PRESCALE(4)) dut (
    .sys_clock(sys_clock), .reset(reset), .cmd(cmd),
    .led_o(led_o), .led_t(led_t), .busy(busy), .fifo_level(fifo_level)
  );
  always #5 sys_clock = ~sys_clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge sys_clock);
    #1;
  endtask
  task automatic push1(input logic [3:0] p, input logic [7:0] h, input logic [3:0] d);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_pattern = p;
    cmd.cmd_hold = h;
    cmd.cmd_duty = d;
    check("push_ready", cmd.cmd_ready, 1);
    step();
    cmd.cmd_valid = 1'b0;
  endtask
  initial begin
    logic [3:0] samp [32];
    logic [3:0] got [8];
    logic [3:0] prev_t;
    int hi0, hi1, rises, k, ngot, cnt;
    logic acc, saw_full;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_pattern = 4'h0;
    cmd.cmd_hold = 8'h0;
    cmd.cmd_duty = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_led_t", led_t, 4'hF);
      check("rst_led_o", led_o, 4'h0);
      check("rst_ready", cmd.cmd_ready, 0);
      check("rst_level", fifo_level, 0);
      check("rst_busy", busy, 0);
    end
    reset = 1'b0;
    #1;
    check("ready_after_rst", cmd.cmd_ready, 1);
    cmd.cmd_pattern = 4'h5;
    cmd.cmd_hold = 8'h9;
    step();
    check("no_valid_level", fifo_level, 0);
    push1(4'hA, 8'd3, 4'hF);
    check("push_level", fifo_level, 1);
    step();
    check("n1_led_t", led_t, 4'hF);
    step();
    check("n2_led_t", led_t, 4'hF);
    for (int i = 0; i < 12; i++) begin
      step();
      check("show_led_t", led_t, 4'h0);
      check("show_led_o", led_o, 4'hA);
    end
    step();
    check("end_led_t", led_t, 4'hF);
    check("end_led_o", led_o, 4'h0);
    check("end_busy", busy, 0);
    push1(4'hF, 8'd8, 4'd4);
    step();
    step();
    hi0 = 0;
    hi1 = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      check("pwm_led_t", led_t, 4'h0);
      check("pwm_uniform", (led_o == 4'h0) || (led_o == 4'hF), 1);
      samp[i] = led_o;
      if (led_o == 4'hF) begin
        if (i < 16) hi0++;
        else hi1++;
      end
    end
    check("pwm_win0_high", hi0, 4);
    check("pwm_win1_high", hi1, 4);
    rises = 0;
    for (int i = 0; i < 32; i++)
      if (samp[i] == 4'hF && samp[(i + 31) % 32] != 4'hF) rises++;
    check("pwm_consecutive", rises, 2);
    step();
    check("pwm_end_led_t", led_t, 4'hF);
    for (int i = 0; i < 8; i++) got[i] = 4'h0;
    k = 0;
    ngot = 0;
    saw_full = 1'b0;
    prev_t = 4'hF;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_pattern = 4'd1;
    cmd.cmd_hold = 8'd2;
    cmd.cmd_duty = 4'hF;
    for (int c = 0; c < 150; c++) begin
      acc = cmd.cmd_valid && cmd.cmd_ready;
      step();
      if (acc) begin
        k++;
        if (k < 7) cmd.cmd_pattern = 4'(k + 1);
        else cmd.cmd_valid = 1'b0;
      end
      if (fifo_level == 3'd4) begin
        saw_full = 1'b1;
        check("full_ready", cmd.cmd_ready, 0);
      end
      if (prev_t == 4'hF && led_t == 4'h0 && ngot < 8) begin
        got[ngot] = led_o;
        ngot++;
      end
      prev_t = led_t;
    end
    check("burst_accepted", k, 7);
    check("burst_saw_full", saw_full, 1);
    check("burst_shown", ngot, 7);
    for (int i = 0; i < 7; i++) check("burst_order", got[i], i + 1);
    check("burst_idle", busy, 0);
    push1(4'hF, 8'd0, 4'hF);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (led_t == 4'h0) cnt++;
    end
    check("hold0_len", cnt, 4);
    for (int i = 0; i < 4; i++) push1(4'(i + 1), 8'd3, 4'hF);
    step();
    check("pre_rst_led_t", led_t, 4'h0);
    check("pre_rst_level", fifo_level, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_led_t", led_t, 4'hF);
    check("mid_rst_led_o", led_o, 4'h0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (led_t != 4'hF || fifo_level != 3'd0) cnt++;
    end
    check("post_rst_quiet", cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
